pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the 8-bit accumulator computer; it replaces the free-running PC and sits directly upstream of the instruction memory, driving its address. Each cycle it selects the next PC: sequential increment, unconditional or flag-conditional jump, subroutine call/return through a small hardware return stack, or halt. Status flags (Z, N, C) are captured from the ALU output on request and drive the conditional jumps.

## Interface

- PC_W, 8, PC / address width
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- seq_op  in  4  sequencing command from the control unit (encoding below)
- target  in  PC_W  jump/call destination (instruction literal field)
- flag_load  in  1  capture flags from ALU this cycle
- alu_result  in  8  ALU output bus
- alu_carry  in  1  ALU carry/borrow out
- pc  out  PC_W  current instruction address
- flags  out  3  registered {C, N, Z}
- depth  out  $clog2(STACK_DEPTH)+1  return-stack occupancy
- halted  out  1  sequencer stopped
- stack_err  out  1  sticky overflow/underflow indicator

## Operation

- seq_op encoding: 0 NXT, 1 JMP, 2 JEQ (Z), 3 JNE (!Z), 4 JGT (!N & !Z), 5 JLT (N), 6 JGE (!N), 7 JLE (N | Z), 8 JCR (C), 9 CALL, 10 RET, 11 HALT; 12–15 behave as NXT.
- NXT, or conditional jump with condition false: pc ← pc+1, wrapping 0xFF → 0x00.
- JMP, or conditional jump with condition true: pc ← target.
- Conditions use the registered flags only. When flag_load and a conditional jump occur in the same cycle, the jump uses the old flags; new flags are visible next cycle.
- flag_load: Z ← (alu_result == 0), N ← alu_result[7], C ← alu_carry. Otherwise flags hold. Independent of seq_op, and also updates while halted.
- CALL, stack not full: push pc+1 (wrapped), pc ← target, depth+1.
- CALL, stack full: no push, depth unchanged, pc ← pc+1, stack_err ← 1.
- RET, stack not empty: pc ← top entry, pop, depth−1.
- RET, stack empty: pc ← pc+1, stack_err ← 1.
- HALT: pc holds, halted ← 1. While halted, all seq_op are ignored, and pc, stack and stack_err freeze. Only rst exits the halted state.
- stack_err is sticky until rst.

## Timing

- Reset (rst high at a clk edge): pc = 0, flags = 0, depth = 0, halted = 0, stack_err = 0. Stack contents are don't-care. rst overrides every seq_op in the same cycle. Reset mid-call discards all return addresses.
- All outputs are registered and change only on the rising clk edge.
- One command per cycle; the effect appears on pc after exactly one edge (zero-bubble, no stall input).
- seq_op, target and flag_load are sampled at the edge. pc feeds the asynchronous instruction memory combinationally, so the instruction at the new pc is decoded in the following cycle.
- The stack is LIFO, with top-of-stack at index depth−1. A CALL immediately followed by a RET returns to the instruction after the CALL.

## Structure

- Shared package pc_seq_pkg: seq_op enum (SEQ_NXT … SEQ_HALT), flag bit indices (FLAG_Z = 0, FLAG_N = 1, FLAG_C = 2), condition-evaluation function.
- Sub-module return_stack:
  - parameters DEPTH, W
  - ports clk, rst, push, pop, din, dout, depth, full, empty
  - push/pop are never asserted together
- The top level holds the pc register, flags register, halted/stack_err flags and next-pc mux.

## Test plan

- Reset, then NXT for 3 cycles → pc 0, 1, 2, 3. Force pc = 0xFF via JMP 0xFF, then NXT → pc = 0x00.
- flag_load with alu_result = 0x00, carry = 0, then JEQ 0x40 → pc = 0x40. Same sequence with alu_result = 0x80 → flags N = 1, Z = 0; JEQ falls through; JLT 0x20 → pc = 0x20.
- Same-cycle flag_load (result 0x00) with JEQ 0x10 while Z = 0 → pc = old+1, flags Z = 1 next cycle.
- At pc = 0x05, CALL 0x30 → pc = 0x30, depth = 1. Then RET → pc = 0x06, depth = 0.
- Five nested CALLs → depth = 4, fifth CALL gives pc+1 and stack_err = 1. Five RETs → four correct returns, fifth gives pc+1 and depth = 0.
- HALT at pc = 0x12 → pc stays 0x12 for 10 cycles despite JMP/CALL inputs. rst → pc = 0, halted = 0, depth = 0, stack_err = 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: command encoding,
// flag bit positions and the conditional-jump evaluator.
package pc_seq_pkg;

   typedef enum logic [3:0] {
      SEQ_NXT  = 4'd0,
      SEQ_JMP  = 4'd1,
      SEQ_JEQ  = 4'd2,
      SEQ_JNE  = 4'd3,
      SEQ_JGT  = 4'd4,
      SEQ_JLT  = 4'd5,
      SEQ_JGE  = 4'd6,
      SEQ_JLE  = 4'd7,
      SEQ_JCR  = 4'd8,
      SEQ_CALL = 4'd9,
      SEQ_RET  = 4'd10,
      SEQ_HALT = 4'd11
   } seq_op_e;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_W = 3;

   // True when a conditional jump should be taken; false for non-conditional ops.
   function automatic logic cond_true(input logic [3:0] op, input logic [FLAG_W-1:0] f);
      logic z, n, c;
      z = f[FLAG_Z];
      n = f[FLAG_N];
      c = f[FLAG_C];
      case (op)
         SEQ_JEQ: cond_true = z;
         SEQ_JNE: cond_true = ~z;
         SEQ_JGT: cond_true = ~n & ~z;
         SEQ_JLT: cond_true = n;
         SEQ_JGE: cond_true = ~n;
         SEQ_JLE: cond_true = n | z;
         SEQ_JCR: cond_true = c;
         default: cond_true = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack; top of stack lives at index depth-1.
module return_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] top_idx;

   assign top_idx = AW'(depth - DW'(1));
   assign dout    = mem[top_idx];
   assign full    = (depth == DW'(DEPTH));
   assign empty   = (depth == '0);

   // Occupancy counter; contents need no reset since depth gates every read.
   always_ff @(posedge clk) begin
      if (rst) begin
         depth <= '0;
      end else if (push && !full) begin
         depth <= depth + DW'(1);
      end else if (pop && !empty) begin
         depth <= depth - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[depth[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next instruction address each cycle
// from increment, jumps, call/return and halt, with ALU-captured status flags.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [3:0]                      seq_op,
   input  logic [PC_W-1:0]                 target,
   input  logic                            flag_load,
   input  logic [7:0]                      alu_result,
   input  logic                            alu_carry,
   output logic [PC_W-1:0]                 pc,
   output logic [2:0]                      flags,
   output logic [$clog2(STACK_DEPTH):0]    depth,
   output logic                            halted,
   output logic                            stack_err
);

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_nxt;
   logic [2:0]      flags_nxt;
   logic            halted_nxt;
   logic            err_nxt;
   logic            push;
   logic            pop;
   logic [PC_W-1:0] stk_top;
   logic            stk_full;
   logic            stk_empty;

   assign pc_inc = pc + PC_W'(1);

   return_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (PC_W)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (stk_top),
      .depth (depth),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // Next-state selection; a halted sequencer ignores every command.
   always_comb begin
      pc_nxt     = pc;
      halted_nxt = halted;
      err_nxt    = stack_err;
      push       = 1'b0;
      pop        = 1'b0;

      if (!halted) begin
         case (seq_op)
            SEQ_JMP: pc_nxt = target;
            SEQ_JEQ, SEQ_JNE, SEQ_JGT, SEQ_JLT,
            SEQ_JGE, SEQ_JLE, SEQ_JCR: begin
               pc_nxt = cond_true(seq_op, flags) ? target : pc_inc;
            end
            SEQ_CALL: begin
               if (!stk_full) begin
                  push   = 1'b1;
                  pc_nxt = target;
               end else begin
                  pc_nxt  = pc_inc;
                  err_nxt = 1'b1;
               end
            end
            SEQ_RET: begin
               if (!stk_empty) begin
                  pop    = 1'b1;
                  pc_nxt = stk_top;
               end else begin
                  pc_nxt  = pc_inc;
                  err_nxt = 1'b1;
               end
            end
            SEQ_HALT: halted_nxt = 1'b1;
            default:  pc_nxt = pc_inc;
         endcase
      end

      // Flags track the ALU whenever requested, even while halted.
      flags_nxt = flags;
      if (flag_load) begin
         flags_nxt[FLAG_Z] = (alu_result == 8'h00);
         flags_nxt[FLAG_N] = alu_result[7];
         flags_nxt[FLAG_C] = alu_carry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= '0;
         flags     <= '0;
         halted    <= 1'b0;
         stack_err <= 1'b0;
      end else begin
         pc        <= pc_nxt;
         flags     <= flags_nxt;
         halted    <= halted_nxt;
         stack_err <= err_nxt;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, halt/reset
// sequence, then randomized commands against a queue-based reference model.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int unsigned PC_W = 8;
   localparam int unsigned SD   = 4;
   localparam int unsigned DW   = $clog2(SD) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      seq_op;
   logic [PC_W-1:0] target;
   logic            flag_load;
   logic [7:0]      alu_result;
   logic            alu_carry;
   logic [PC_W-1:0] pc;
   logic [2:0]      flags;
   logic [DW-1:0]   depth;
   logic            halted;
   logic            stack_err;

   always #5 clk = ~clk;

   pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(SD)) dut (
      .clk        (clk),
      .rst        (rst),
      .seq_op     (seq_op),
      .target     (target),
      .flag_load  (flag_load),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .pc         (pc),
      .flags      (flags),
      .depth      (depth),
      .halted     (halted),
      .stack_err  (stack_err)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] op;
      logic [7:0] tgt;
      logic       fl;
      logic [7:0] res;
      logic       cy;
      logic [7:0] e_pc;
      logic [2:0] e_flags;
      int         e_depth;
      logic       e_halt;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: plain integers and a queue for the return stack.
   int   m_pc;
   bit   m_z, m_n, m_c;
   int   m_stk[$];
   bit   m_halt, m_err;

   task automatic check(input string name, input logic [7:0] epc, input logic [2:0] ef,
                        input int ed, input logic eh, input logic ee);
      checks++;
      if (pc !== epc || flags !== ef || depth !== DW'(ed) || halted !== eh || stack_err !== ee) begin
         errors++;
         $display("FAIL %s: got pc=%h flags=%b depth=%0d halted=%b err=%b, want pc=%h flags=%b depth=%0d halted=%b err=%b",
                  name, pc, flags, depth, halted, stack_err, epc, ef, ed, eh, ee);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] op, input logic [7:0] tg,
                       input logic fl, input logic [7:0] res, input logic cy);
      rst        = r;
      seq_op     = op;
      target     = tg;
      flag_load  = fl;
      alu_result = res;
      alu_carry  = cy;
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_cond(input int op);
      case (op)
         2: return m_z;
         3: return !m_z;
         4: return !m_n && !m_z;
         5: return m_n;
         6: return !m_n;
         7: return m_n || m_z;
         8: return m_c;
         default: return 0;
      endcase
   endfunction

   // Advance the model by one clock using the rules of the instruction set.
   task automatic m_step(input bit r, input int op, input int tg, input bit fl,
                         input int res, input bit cy);
      if (r) begin
         m_pc = 0; m_z = 0; m_n = 0; m_c = 0;
         m_stk.delete(); m_halt = 0; m_err = 0;
         return;
      end
      if (!m_halt) begin
         if (op == 1) m_pc = tg;
         else if (op >= 2 && op <= 8) m_pc = m_cond(op) ? tg : (m_pc + 1) % 256;
         else if (op == 9) begin
            if (m_stk.size() < SD) begin
               m_stk.push_back((m_pc + 1) % 256);
               m_pc = tg;
            end else begin
               m_pc = (m_pc + 1) % 256; m_err = 1;
            end
         end else if (op == 10) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
               m_pc = (m_pc + 1) % 256; m_err = 1;
            end
         end else if (op == 11) m_halt = 1;
         else m_pc = (m_pc + 1) % 256;
      end
      if (fl) begin
         m_z = (res == 0); m_n = res[7]; m_c = cy;
      end
   endtask

   initial begin
      // op, target, flag_load, result, carry | pc, {C,N,Z}, depth, halted, err
      vecs.push_back('{4'd0,  8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 3'b000, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd0,  8'h00, 1'b0, 8'h00, 1'b0, 8'h02, 3'b000, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd0,  8'h00, 1'b0, 8'h00, 1'b0, 8'h03, 3'b000, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd1,  8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 3'b000, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd0,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd0,  8'h00, 1'b1, 8'h00, 1'b0, 8'h01, 3'b001, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd2,  8'h40, 1'b0, 8'h00, 1'b0, 8'h40, 3'b001, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd0,  8'h00, 1'b1, 8'h80, 1'b0, 8'h41, 3'b010, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd2,  8'h40, 1'b0, 8'h00, 1'b0, 8'h42, 3'b010, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd5,  8'h20, 1'b0, 8'h00, 1'b0, 8'h20, 3'b010, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd2,  8'h10, 1'b1, 8'h00, 1'b0, 8'h21, 3'b001, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd2,  8'h10, 1'b0, 8'h00, 1'b0, 8'h10, 3'b001, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd1,  8'h05, 1'b0, 8'h00, 1'b0, 8'h05, 3'b001, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd9,  8'h30, 1'b0, 8'h00, 1'b0, 8'h30, 3'b001, 1, 1'b0, 1'b0});
      vecs.push_back('{4'd10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h06, 3'b001, 0, 1'b0, 1'b0});
      vecs.push_back('{4'd9,  8'h50, 1'b0, 8'h00, 1'b0, 8'h50, 3'b001, 1, 1'b0, 1'b0});
      vecs.push_back('{4'd9,  8'h60, 1'b0, 8'h00, 1'b0, 8'h60, 3'b001, 2, 1'b0, 1'b0});
      vecs.push_back('{4'd9,  8'h70, 1'b0, 8'h00, 1'b0, 8'h70, 3'b001, 3, 1'b0, 1'b0});
      vecs.push_back('{4'd9,  8'h80, 1'b0, 8'h00, 1'b0, 8'h80, 3'b001, 4, 1'b0, 1'b0});
      vecs.push_back('{4'd9,  8'h90, 1'b0, 8'h00, 1'b0, 8'h81, 3'b001, 4, 1'b0, 1'b1});
      vecs.push_back('{4'd10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h71, 3'b001, 3, 1'b0, 1'b1});
      vecs.push_back('{4'd10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h61, 3'b001, 2, 1'b0, 1'b1});
      vecs.push_back('{4'd10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h51, 3'b001, 1, 1'b0, 1'b1});
      vecs.push_back('{4'd10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h07, 3'b001, 0, 1'b0, 1'b1});
      vecs.push_back('{4'd10, 8'h00, 1'b0, 8'h00, 1'b0, 8'h08, 3'b001, 0, 1'b0, 1'b1});
      vecs.push_back('{4'd8,  8'h33, 1'b1, 8'h01, 1'b1, 8'h09, 3'b100, 0, 1'b0, 1'b1});
      vecs.push_back('{4'd8,  8'h33, 1'b0, 8'h00, 1'b0, 8'h33, 3'b100, 0, 1'b0, 1'b1});
      vecs.push_back('{4'd4,  8'hAA, 1'b0, 8'h00, 1'b0, 8'hAA, 3'b100, 0, 1'b0, 1'b1});
      vecs.push_back('{4'd7,  8'h00, 1'b0, 8'h00, 1'b0, 8'hAB, 3'b100, 0, 1'b0, 1'b1});
      vecs.push_back('{4'd3,  8'hC0, 1'b0, 8'h00, 1'b0, 8'hC0, 3'b100, 0, 1'b0, 1'b1});
      vecs.push_back('{4'd6,  8'h12, 1'b0, 8'h00, 1'b0, 8'h12, 3'b100, 0, 1'b0, 1'b1});
      vecs.push_back('{4'd11, 8'h00, 1'b0, 8'h00, 1'b0, 8'h12, 3'b100, 0, 1'b1, 1'b1});
      vecs.push_back('{4'd1,  8'h44, 1'b0, 8'h00, 1'b0, 8'h12, 3'b100, 0, 1'b1, 1'b1});
      vecs.push_back('{4'd9,  8'h44, 1'b1, 8'hFF, 1'b0, 8'h12, 3'b010, 0, 1'b1, 1'b1});
      vecs.push_back('{4'd15, 8'h44, 1'b0, 8'h00, 1'b0, 8'h12, 3'b010, 0, 1'b1, 1'b1});

      rst = 1'b1; seq_op = '0; target = '0; flag_load = 1'b0; alu_result = '0; alu_carry = 1'b0;
      #2;
      step(1'b1, 4'd9, 8'h77, 1'b1, 8'h80, 1'b1);
      check("reset", 8'h00, 3'b000, 0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         step(1'b0, vecs[i].op, vecs[i].tgt, vecs[i].fl, vecs[i].res, vecs[i].cy);
         check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_flags, vecs[i].e_depth,
               vecs[i].e_halt, vecs[i].e_err);
      end

      // Halted sequencer ignores jumps and calls for many cycles.
      for (int k = 0; k < 10; k++) begin
         step(1'b0, (k % 2 == 0) ? 4'd1 : 4'd9, 8'h66, 1'b0, 8'h00, 1'b0);
         check($sformatf("halt_hold%0d", k), 8'h12, 3'b010, 0, 1'b1, 1'b1);
      end
      step(1'b1, 4'd1, 8'h66, 1'b0, 8'h00, 1'b0);
      check("halt_reset", 8'h00, 3'b000, 0, 1'b0, 1'b0);

      // Reset mid-call discards return addresses.
      step(1'b0, 4'd9, 8'h20, 1'b0, 8'h00, 1'b0);
      step(1'b0, 4'd9, 8'h30, 1'b0, 8'h00, 1'b0);
      check("two_calls", 8'h30, 3'b000, 2, 1'b0, 1'b0);
      step(1'b1, 4'd10, 8'h00, 1'b0, 8'h00, 1'b0);
      check("reset_mid_call", 8'h00, 3'b000, 0, 1'b0, 1'b0);
      step(1'b0, 4'd10, 8'h00, 1'b0, 8'h00, 1'b0);
      check("ret_after_reset", 8'h01, 3'b000, 0, 1'b0, 1'b1);

      // Randomized commands against the reference model.
      m_step(1'b1, 0, 0, 0, 0, 0);
      step(1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 3000; k++) begin
         bit   r, fl, cy;
         int   op, tg, res, sel;
         r   = ($urandom_range(0, 59) == 0);
         sel = $urandom_range(0, 99);
         op  = (sel < 2) ? 11 : $urandom_range(0, 15);
         if (op == 11 && sel >= 2) op = 0;
         if (sel >= 2 && sel < 20) op = 9 + $urandom_range(0, 1);
         tg  = $urandom_range(0, 255);
         fl  = $urandom_range(0, 1);
         res = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
         cy  = $urandom_range(0, 1);
         m_step(r, op, tg, fl, res, cy);
         step(r, 4'(op), 8'(tg), fl, 8'(res), cy);
         check($sformatf("rand%0d", k), 8'(m_pc), {m_c, m_n, m_z}, m_stk.size(), m_halt, m_err);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
